// File: rtl/lc3b_pkg.sv
// Shared LC-3b register-file constants and types.
package lc3b_pkg;
  localparam int WORD_W    = 16;
  localparam int REG_CNT   = 8;
  localparam int REG_IDX_W = 3;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/lc3b_reg16.sv
// One register-file word: async active-low clear, synchronous load enable.
module lc3b_reg16
  import lc3b_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) q_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_q == q_d ? q_q : q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/lc3b_regs.sv
// LC-3b general-purpose register file: R0-R7, one write port, two async read ports.
// Define LC3B_REGS_BYPASS_EN to forward write data to a matching read port in the same cycle.
module lc3b_regs #(
  parameter int WORD_W = lc3b_pkg::WORD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WORD_W-1:0]       data,
  input  logic                    ld_reg,
  input  lc3b_pkg::reg_idx_t      dr,
  input  lc3b_pkg::reg_idx_t      sr1,
  input  lc3b_pkg::reg_idx_t      sr2,
  output logic [WORD_W-1:0]       sr1_out,
  output logic [WORD_W-1:0]       sr2_out
);
  import lc3b_pkg::REG_CNT;

  logic [REG_CNT-1:0]             wr_en;
  logic [REG_CNT-1:0][WORD_W-1:0] regs;

  always_comb begin
    wr_en = '0;
    if (ld_reg) wr_en[dr] = 1'b1;
  end

  for (genvar i = 0; i < REG_CNT; i++) begin : g_reg
    lc3b_reg16 #(.W(WORD_W)) u_reg (
      .clk   (clk),
      .rst_n (rst),
      .ld    (wr_en[i]),
      .d     (data),
      .q     (regs[i])
    );
  end

`ifdef LC3B_REGS_BYPASS_EN
  // Forwarding is gated by rst so outputs stay zero during reset.
  always_comb begin
    sr1_out = regs[sr1];
    sr2_out = regs[sr2];
    if (rst && ld_reg && dr == sr1) sr1_out = data;
    if (rst && ld_reg && dr == sr2) sr2_out = data;
  end
`else
  always_comb begin
    sr1_out = regs[sr1];
    sr2_out = regs[sr2];
  end
`endif
endmodule

// File: tb/tb_lc3b_regs.sv
// Directed self-checking bench for lc3b_regs (both bypass builds).
module tb_lc3b_regs;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data = '0;
  logic        ld_reg = 1'b0;
  logic [2:0]  dr = '0, sr1 = '0, sr2 = '0;
  logic [15:0] sr1_out, sr2_out;

  int n_cmp = 0;
  int n_bad = 0;

  lc3b_regs dut (
    .clk(clk), .rst(rst), .data(data), .ld_reg(ld_reg),
    .dr(dr), .sr1(sr1), .sr2(sr2), .sr1_out(sr1_out), .sr2_out(sr2_out)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clk);
    ld_reg = 1'b1; dr = idx; data = val;
    @(posedge clk); #1;
    ld_reg = 1'b0;
  endtask

  logic [15:0] rdw_exp;

  initial begin
    // reset state
    #3;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i); #1;
      chk("rst_init_sr1", sr1_out, 16'h0000);
      chk("rst_init_sr2", sr2_out, 16'h0000);
    end
    @(negedge clk); rst = 1'b1;

    // write all, independent sweeps
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1111 * (i + 1)));
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i); #1;
      chk("wall_sr1", sr1_out, 16'(16'h1111 * (i + 1)));
      chk("wall_sr2", sr2_out, 16'(16'h1111 * (8 - i)));
    end

    // load gating
    @(negedge clk);
    ld_reg = 1'b0; dr = 3'd3; data = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1; sr1 = 3'd3; #1;
    chk("ld_gate_r3", sr1_out, 16'h4444);

    // dual read
    wr(3'd5, 16'hA5A5);
    sr1 = 3'd5; sr2 = 3'd5; #1;
    chk("dual_sr1", sr1_out, 16'hA5A5);
    chk("dual_sr2", sr2_out, 16'hA5A5);

    // read-during-write
    wr(3'd2, 16'h0001);
    @(negedge clk);
    sr1 = 3'd2; sr2 = 3'd6;
    ld_reg = 1'b1; dr = 3'd2; data = 16'hBEEF; #1;
`ifdef LC3B_REGS_BYPASS_EN
    rdw_exp = 16'hBEEF;
`else
    rdw_exp = 16'h0001;
`endif
    chk("rdw_before", sr1_out, rdw_exp);
    chk("rdw_other", sr2_out, 16'h7777);
    @(posedge clk); #1;
    ld_reg = 1'b0; #1;
    chk("rdw_after", sr1_out, 16'hBEEF);

    // async reset pulse inside the low phase, no clock edge involved
    @(negedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i); #1;
      chk("rst_pulse_sr1", sr1_out, 16'h0000);
      chk("rst_pulse_sr2", sr2_out, 16'h0000);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    sr1 = 3'd7; #1;
    chk("rst_pulse_hold", sr1_out, 16'h0000);

    // reset dominates a coincident write
    wr(3'd4, 16'h1234);
    sr1 = 3'd4; #1;
    chk("pre_rvw_r4", sr1_out, 16'h1234);
    @(negedge clk);
    ld_reg = 1'b1; dr = 3'd4; data = 16'h7FFF; sr1 = 3'd4; sr2 = 3'd5;
    @(posedge clk);
    rst = 1'b0;
    #1;
    chk("rvw_sr1", sr1_out, 16'h0000);
    chk("rvw_sr2", sr2_out, 16'h0000);
    @(negedge clk);
    ld_reg = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rvw_r4_after", sr1_out, 16'h0000);

    // first write after reset release lands
    wr(3'd4, 16'h7FFF);
    chk("post_rst_wr", sr1_out, 16'h7FFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
